bcd_a_binario_secuencial: RTL and testbench

Iterative packed-BCD to unsigned-binary converter. It performs the inverse of the team's binary-to-BCD display converters, using reverse double-dabble: shift right one bit per clock and subtract 3 from any digit that is 8 or more. It sits between BCD keypad or switch capture logic and the binary datapath. Valid/ready handshakes are used on both the input and output sides.

---
 rtl/bcd_a_binario_secuencial.sv | 134 +++++++++++++
 tb/tb_bcd_a_binario_secuencial.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_a_binario_secuencial.sv
// Iterative packed-BCD to binary converter (reverse double-dabble, one bit per clock).
// Optional input digit checking is enabled by defining BCD_DETECCION_ERROR_EN.
module bcd_a_binario_secuencial #(
   parameter int DIGITOS   = 2,
   parameter int ANCHO_BIN = 7
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [4*DIGITOS-1:0]   entrada_bcd,
   input  logic                   entrada_valida,
   output logic                   entrada_lista,
   output logic [ANCHO_BIN-1:0]   salida_binario,
   output logic                   salida_valida,
   input  logic                   salida_lista,
   output logic                   salida_error
);

   localparam int ANCHO_BCD = 4 * DIGITOS;
   localparam int ANCHO_CNT = (ANCHO_BIN > 1) ? $clog2(ANCHO_BIN) : 1;
   localparam logic [ANCHO_CNT-1:0] ULTIMO = ANCHO_CNT'(ANCHO_BIN - 1);

   typedef enum logic [1:0] {REPOSO, CONVIRTIENDO, LISTO} estado_t;

   estado_t                 estado_reg, estado_next;
   logic [ANCHO_BCD-1:0]    bcd_reg;
   logic [ANCHO_BIN-1:0]    bin_reg;
   logic [ANCHO_CNT-1:0]    cnt_reg;
   logic [ANCHO_BIN-1:0]    salida_binario_reg;
   logic                    salida_valida_reg;
   logic                    error_activo;

   logic [ANCHO_BCD+ANCHO_BIN-1:0] desplazado;
   logic [ANCHO_BCD-1:0]    bcd_desp;
   logic [ANCHO_BCD-1:0]    bcd_corr;
   logic [ANCHO_BIN-1:0]    bin_desp;

   assign desplazado = {bcd_reg, bin_reg} >> 1;
   assign bcd_desp   = desplazado[ANCHO_BCD+ANCHO_BIN-1:ANCHO_BIN];
   assign bin_desp   = desplazado[ANCHO_BIN-1:0];

   // Each digit is corrected independently; a digit of 8+ came from a borrowed 10 (16 -> 10 after halving).
   generate
      for (genvar gi = 0; gi < DIGITOS; gi++) begin : g_correccion
         assign bcd_corr[gi*4 +: 4] = (bcd_desp[gi*4 +: 4] >= 4'd8) ?
                                      (bcd_desp[gi*4 +: 4] - 4'd3) : bcd_desp[gi*4 +: 4];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) estado_reg <= REPOSO;
      else     estado_reg <= estado_next;
   end

   always_comb begin
      estado_next = estado_reg;
      case (estado_reg)
         REPOSO:       if (entrada_valida)   estado_next = CONVIRTIENDO;
         CONVIRTIENDO: if (cnt_reg == ULTIMO) estado_next = LISTO;
         LISTO:        if (salida_lista)     estado_next = REPOSO;
         default:                            estado_next = REPOSO;
      endcase
   end

   assign entrada_lista = (estado_reg == REPOSO);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd_reg            <= '0;
         bin_reg            <= '0;
         cnt_reg            <= '0;
         salida_binario_reg <= '0;
         salida_valida_reg  <= 1'b0;
      end else begin
         case (estado_reg)
            REPOSO: begin
               if (entrada_valida) begin
                  bcd_reg <= entrada_bcd;
                  bin_reg <= '0;
                  cnt_reg <= '0;
               end
            end
            CONVIRTIENDO: begin
               bcd_reg <= bcd_corr;
               bin_reg <= bin_desp;
               cnt_reg <= cnt_reg + ANCHO_CNT'(1);
               if (cnt_reg == ULTIMO) begin
                  salida_binario_reg <= error_activo ? '0 : bin_desp;
                  salida_valida_reg  <= 1'b1;
               end
            end
            LISTO: begin
               if (salida_lista) salida_valida_reg <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef BCD_DETECCION_ERROR_EN
   logic [DIGITOS-1:0] digito_invalido;
   logic               error_captura_reg;
   logic               salida_error_reg;

   generate
      for (genvar gi = 0; gi < DIGITOS; gi++) begin : g_chequeo
         assign digito_invalido[gi] = (entrada_bcd[gi*4 +: 4] > 4'd9);
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         error_captura_reg <= 1'b0;
         salida_error_reg  <= 1'b0;
      end else begin
         if (estado_reg == REPOSO && entrada_valida)
            error_captura_reg <= |digito_invalido;
         if (estado_reg == CONVIRTIENDO && cnt_reg == ULTIMO)
            salida_error_reg <= error_captura_reg;
         else if (estado_reg == LISTO && salida_lista)
            salida_error_reg <= 1'b0;
      end
   end

   assign error_activo = error_captura_reg;
   assign salida_error = salida_error_reg;
`else
   assign error_activo = 1'b0;
   assign salida_error = 1'b0;
`endif

   assign salida_binario = salida_binario_reg;
   assign salida_valida  = salida_valida_reg;

endmodule

// File: tb/tb_bcd_a_binario_secuencial.sv
// Self-checking bench for bcd_a_binario_secuencial; covers BCD_DETECCION_ERROR_EN when defined.
module tb_bcd_a_binario_secuencial;

   localparam int DIGITOS   = 2;
   localparam int ANCHO_BIN = 7;
   localparam int W         = 4 * DIGITOS;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [W-1:0]         entrada_bcd;
   logic                 entrada_valida;
   logic                 entrada_lista;
   logic [ANCHO_BIN-1:0] salida_binario;
   logic                 salida_valida;
   logic                 salida_lista;
   logic                 salida_error;

   int tests_run = 0;
   int failed    = 0;

   always #5 clk = ~clk;

   bcd_a_binario_secuencial #(.DIGITOS(DIGITOS), .ANCHO_BIN(ANCHO_BIN)) dut (
      .clk            (clk),
      .rst            (rst),
      .entrada_bcd    (entrada_bcd),
      .entrada_valida (entrada_valida),
      .entrada_lista  (entrada_lista),
      .salida_binario (salida_binario),
      .salida_valida  (salida_valida),
      .salida_lista   (salida_lista),
      .salida_error   (salida_error)
   );

   // Reference: decimal value of the packed BCD word, most significant digit first.
   function automatic int modelo(input logic [W-1:0] w);
      int v = 0;
      for (int i = DIGITOS - 1; i >= 0; i--) v = v * 10 + int'(w[i*4 +: 4]);
      return v;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] w;
      for (int i = 0; i < DIGITOS; i++) w[i*4 +: 4] = 4'($urandom_range(0, 9));
      return w;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word, wait for the result (bounded); leaves the result unconsumed.
   task automatic run_word(input logic [W-1:0] w, output int lat,
                           output logic [ANCHO_BIN-1:0] res, output logic err);
      entrada_bcd    = w;
      entrada_valida = 1'b1;
      step();
      entrada_valida = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (salida_valida) begin
            lat = n;
            break;
         end
      end
      res = salida_binario;
      err = salida_error;
      $display("[TB] word %h -> %0d err=%0b latency=%0d", w, res, err, lat);
   endtask

   task automatic release_out();
      salida_lista = 1'b1;
      step();
      salida_lista = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; entrada_bcd = '0; entrada_valida = 1'b0; salida_lista = 1'b0;
      step(); step();
      tests_run++;
      if (salida_valida !== 1'b0) begin failed++; $display("FAIL reset_valida got=%b exp=0", salida_valida); end
      tests_run++;
      if (salida_binario !== '0) begin failed++; $display("FAIL reset_binario got=%0d exp=0", salida_binario); end
      tests_run++;
      if (salida_error !== 1'b0) begin failed++; $display("FAIL reset_error got=%b exp=0", salida_error); end
      tests_run++;
      if (entrada_lista !== 1'b1) begin failed++; $display("FAIL reset_lista got=%b exp=1", entrada_lista); end
      @(negedge clk) rst = 1'b0;
      step();
      tests_run++;
      if (entrada_lista !== 1'b1) begin failed++; $display("FAIL post_reset_lista got=%b exp=1", entrada_lista); end
   endtask

   task automatic test_convert(input logic [W-1:0] w);
      int lat; logic [ANCHO_BIN-1:0] res; logic err;
      run_word(w, lat, res, err);
      tests_run++;
      if (lat !== ANCHO_BIN) begin failed++; $display("FAIL latency word=%h got=%0d exp=%0d", w, lat, ANCHO_BIN); end
      tests_run++;
      if (int'(res) !== modelo(w)) begin failed++; $display("FAIL result word=%h got=%0d exp=%0d", w, res, modelo(w)); end
      tests_run++;
      if (err !== 1'b0) begin failed++; $display("FAIL error_flag word=%h got=%b exp=0", w, err); end
      release_out();
      tests_run++;
      if (salida_valida !== 1'b0 || entrada_lista !== 1'b1) begin
         failed++; $display("FAIL handoff word=%h valida=%b lista=%b exp 0/1", w, salida_valida, entrada_lista);
      end
   endtask

   task automatic test_boundaries();
      logic [W-1:0] nines;
      for (int i = 0; i < DIGITOS; i++) nines[i*4 +: 4] = 4'd9;
      test_convert(nines);
      test_convert('0);
      test_convert(8'h42);
   endtask

   task automatic test_random();
      for (int k = 0; k < 20; k++) test_convert(rand_bcd());
   endtask

   task automatic test_backpressure();
      int lat; logic [ANCHO_BIN-1:0] res; logic err;
      run_word(8'h57, lat, res, err);
      tests_run++;
      if (int'(res) !== 57) begin failed++; $display("FAIL bp_result got=%0d exp=57", res); end
      entrada_bcd = 8'h11; entrada_valida = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         tests_run++;
         if (salida_valida !== 1'b1 || int'(salida_binario) !== 57 || entrada_lista !== 1'b0) begin
            failed++;
            $display("FAIL bp_hold cycle=%0d valida=%b binario=%0d lista=%b exp 1/57/0",
                     c, salida_valida, salida_binario, entrada_lista);
         end
      end
      entrada_valida = 1'b0;
      release_out();
      tests_run++;
      if (salida_valida !== 1'b0 || entrada_lista !== 1'b1) begin
         failed++; $display("FAIL bp_release valida=%b lista=%b exp 0/1", salida_valida, entrada_lista);
      end
      step();
      tests_run++;
      if (entrada_lista !== 1'b1) begin failed++; $display("FAIL bp_ignored lista=%b exp=1", entrada_lista); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [ANCHO_BIN-1:0] res; logic err;
      entrada_bcd = 8'h88; entrada_valida = 1'b1;
      step();
      entrada_valida = 1'b0;
      step(); step(); step();
      tests_run++;
      if (entrada_lista !== 1'b0) begin failed++; $display("FAIL busy_lista got=%b exp=0", entrada_lista); end
      rst = 1'b1;
      #1;
      tests_run++;
      if (salida_valida !== 1'b0 || salida_binario !== '0 || entrada_lista !== 1'b1) begin
         failed++; $display("FAIL mid_reset valida=%b binario=%0d lista=%b exp 0/0/1",
                            salida_valida, salida_binario, entrada_lista);
      end
      @(negedge clk) rst = 1'b0;
      step();
      run_word(8'h12, lat, res, err);
      tests_run++;
      if (lat !== ANCHO_BIN || int'(res) !== 12) begin
         failed++; $display("FAIL after_reset latency=%0d result=%0d exp %0d/12", lat, res, ANCHO_BIN);
      end
      // Abort while the result is waiting for the consumer.
      rst = 1'b1;
      #1;
      tests_run++;
      if (salida_valida !== 1'b0 || salida_binario !== '0 || entrada_lista !== 1'b1) begin
         failed++; $display("FAIL listo_reset valida=%b binario=%0d lista=%b exp 0/0/1",
                            salida_valida, salida_binario, entrada_lista);
      end
      @(negedge clk) rst = 1'b0;
      step();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] cola[$];
      logic [W-1:0] w;
      int last = -1, got = 0;
      salida_lista   = 1'b1;
      entrada_valida = 1'b1;
      w = rand_bcd(); entrada_bcd = w; cola.push_back(w);
      for (int cyc = 1; cyc <= 200 && got < 6; cyc++) begin
         step();
         if (salida_valida) begin
            w = cola.pop_front();
            $display("[TB] b2b word %h -> %0d at cycle %0d", w, salida_binario, cyc);
            tests_run++;
            if (int'(salida_binario) !== modelo(w)) begin
               failed++; $display("FAIL b2b_result word=%h got=%0d exp=%0d", w, salida_binario, modelo(w));
            end
            if (last >= 0) begin
               tests_run++;
               if (cyc - last !== ANCHO_BIN + 2) begin
                  failed++; $display("FAIL b2b_period got=%0d exp=%0d", cyc - last, ANCHO_BIN + 2);
               end
            end
            last = cyc;
            got++;
            if (got == 6) entrada_valida = 1'b0;
         end
         if (entrada_lista && entrada_valida) begin
            w = rand_bcd(); entrada_bcd = w; cola.push_back(w);
         end
      end
      entrada_valida = 1'b0;
      tests_run++;
      if (got !== 6) begin failed++; $display("FAIL b2b_count got=%0d exp=6", got); end
      step(); step();
      salida_lista = 1'b0;
      tests_run++;
      if (entrada_lista !== 1'b1 || salida_valida !== 1'b0) begin
         failed++; $display("FAIL b2b_drain lista=%b valida=%b exp 1/0", entrada_lista, salida_valida);
      end
   endtask

`ifdef BCD_DETECCION_ERROR_EN
   task automatic test_error();
      int lat; logic [ANCHO_BIN-1:0] res; logic err;
      run_word(8'h3A, lat, res, err);
      tests_run++;
      if (lat !== ANCHO_BIN || err !== 1'b1 || res !== '0) begin
         failed++; $display("FAIL err_word latency=%0d err=%b result=%0d exp %0d/1/0", lat, err, res, ANCHO_BIN);
      end
      release_out();
      tests_run++;
      if (salida_error !== 1'b0) begin failed++; $display("FAIL err_clear got=%b exp=0", salida_error); end
      test_convert(8'h25);
   endtask
`endif

   initial begin
      test_reset();
      test_boundaries();
      test_random();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
`ifdef BCD_DETECCION_ERROR_EN
      test_error();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule
